// File: rtl/dmem_banked_rw.sv
// Banked data memory: NUM_RD registered read ports plus one byte-masked write port. A post-reset sweep zeroes words CLR_BASE..depth-1.
// Latency: read data and rd_valid are registered, so they appear 1 cycle after rd_en. A write commits on the clock edge.
// Backpressure: none while running; every request is served in the cycle it arrives. While busy, all requests are dropped.
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-low reset
//   rd_en/rd_addr per-port read request; port p address is rd_addr[p*ADDR_W +: ADDR_W]
//   rd_data       per-port registered read data; port p is rd_data[p*DATA_LEN +: DATA_LEN]
//   rd_valid      per-port one-cycle pulse that marks fresh rd_data
//   wr_en/wr_addr/wr_be/wr_data  write request with per-byte enables
//   busy          high while the clear sweep runs
module dmem_banked_rw #(
  parameter int DATA_LEN = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int CLR_BASE = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_LEN-1:0] rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_LEN/8-1:0]      wr_be,
  input  logic [DATA_LEN-1:0]        wr_data,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_LEN / 8;

  localparam logic [ADDR_W-1:0] CLR_START = ADDR_W'(CLR_BASE);
  localparam logic [ADDR_W-1:0] CLR_LAST  = {ADDR_W{1'b1}};

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clr_we;
  logic                acc_en;
  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [DATA_LEN-1:0] wr_merged;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. The sweep ends on the cycle that clears the top word.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = 1'b1;
    clr_we = 1'b0;
    acc_en = 1'b0;
    case (state)
      S_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      S_RUN: begin
        busy   = 1'b0;
        acc_en = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep counter. It stops at the top word, so it never wraps back into the
  // preserved region below CLR_BASE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt <= CLR_START;
    end else if (clr_we && (clr_cnt != CLR_LAST)) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Post-write image of word[wr_addr]. The array write uses it, and so does
  // any read of the same address in the same cycle, which makes reads
  // write-first.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array. It has no reset, so contents below CLR_BASE survive reset.
  // Reset drives the FSM to CLEAR asynchronously, so a write is never
  // committed once rst is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (acc_en && wr_en) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. rd_data holds its last value when a port is idle; rd_valid is
  // a one-cycle pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_valid[p] <= acc_en && rd_en[p];
        if (acc_en && rd_en[p]) begin
          if (wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
            rd_data[p*DATA_LEN +: DATA_LEN] <= wr_merged;
          end else begin
            rd_data[p*DATA_LEN +: DATA_LEN] <= mem[rd_addr[p*ADDR_W +: ADDR_W]];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_banked_rw.sv
module tb_dmem_banked_rw;

  int tests_run = 0;
  int tests_failed = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (DATA_LEN=16, ADDR_W=5, NUM_RD=2, CLR_BASE=13)
  logic        rst_a;
  logic [1:0]  rd_en_a;
  logic [9:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [1:0]  rd_valid_a;
  logic        wr_en_a;
  logic [4:0]  wr_addr_a;
  logic [1:0]  wr_be_a;
  logic [15:0] wr_data_a;
  logic        busy_a;

  dmem_banked_rw dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a),
    .wr_en    (wr_en_a),
    .wr_addr  (wr_addr_a),
    .wr_be    (wr_be_a),
    .wr_data  (wr_data_a),
    .busy     (busy_a)
  );

  // Wide instance (DATA_LEN=32, ADDR_W=6, NUM_RD=3, CLR_BASE=0)
  logic        rst_b;
  logic [2:0]  rd_en_b;
  logic [17:0] rd_addr_b;
  logic [95:0] rd_data_b;
  logic [2:0]  rd_valid_b;
  logic        wr_en_b;
  logic [5:0]  wr_addr_b;
  logic [3:0]  wr_be_b;
  logic [31:0] wr_data_b;
  logic        busy_b;

  dmem_banked_rw #(
    .DATA_LEN (32),
    .ADDR_W   (6),
    .NUM_RD   (3),
    .CLR_BASE (0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b),
    .wr_en    (wr_en_b),
    .wr_addr  (wr_addr_b),
    .wr_be    (wr_be_b),
    .wr_data  (wr_data_b),
    .busy     (busy_b)
  );

  // All tasks begin and end on a falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_busy_a(output int n);
    n = 0;
    while (busy_a && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    while (busy_b && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en_a   = 1'b1;
    wr_addr_a = a;
    wr_data_a = d;
    wr_be_a   = be;
    cyc();
    wr_en_a = 1'b0;
    wr_be_a = 2'b00;
  endtask

  // Read on one port: returns data and valid one cycle after rd_en, and valid one cycle later.
  task automatic rd_a(input int p, input logic [4:0] a, output logic [15:0] d,
                      output logic v1, output logic v2);
    rd_en_a[p] = 1'b1;
    rd_addr_a[p*5 +: 5] = a;
    cyc();
    d  = rd_data_a[p*16 +: 16];
    v1 = rd_valid_a[p];
    rd_en_a[p] = 1'b0;
    cyc();
    v2 = rd_valid_a[p];
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    tests_run++;
    if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %b expected 1", busy_a); end
    tests_run++;
    if (rd_valid_a !== 2'b00) begin tests_failed++; $display("FAIL reset_rd_valid: got %b expected 00", rd_valid_a); end
    tests_run++;
    if (rd_data_a !== 32'h0) begin tests_failed++; $display("FAIL reset_rd_data: got %h expected 0", rd_data_a); end
    cyc();
    rst_a = 1'b1;
    count_busy_a(n);
    tests_run++;
    if (n !== 19) begin tests_failed++; $display("FAIL reset_sweep_len: got %0d expected 19", n); end
  endtask

  task automatic test_sweep();
    logic [15:0] d;
    logic v1, v2;
    int n;
    wr_a(5'd3, 16'd53, 2'b11);
    wr_a(5'd20, 16'd77, 2'b11);
    rd_en_a[1] = 1'b1;
    rd_addr_a[9:5] = 5'd20;
    cyc();
    rd_en_a[1] = 1'b0;
    tests_run++;
    if (rd_data_a[31:16] !== 16'd77 || rd_valid_a[1] !== 1'b1) begin
      tests_failed++; $display("FAIL preload_read: got %h/%b expected 004d/1", rd_data_a[31:16], rd_valid_a[1]);
    end
    // Asynchronous reset while a valid read result is showing.
    rst_a = 1'b0;
    #1;
    tests_run++;
    if (rd_data_a !== 32'h0 || rd_valid_a !== 2'b00 || busy_a !== 1'b1) begin
      tests_failed++; $display("FAIL async_reset: got data=%h valid=%b busy=%b expected 0/00/1", rd_data_a, rd_valid_a, busy_a);
    end
    @(negedge clk);
    cyc();
    rst_a = 1'b1;
    count_busy_a(n);
    tests_run++;
    if (n !== 19) begin tests_failed++; $display("FAIL sweep_len: got %0d expected 19", n); end
    rd_a(0, 5'd20, d, v1, v2);
    tests_run++;
    if (d !== 16'h0000 || v1 !== 1'b1) begin tests_failed++; $display("FAIL sweep_word20: got %h/%b expected 0000/1", d, v1); end
    rd_a(0, 5'd3, d, v1, v2);
    tests_run++;
    if (d !== 16'd53) begin tests_failed++; $display("FAIL keep_word3: got %0d expected 53", d); end
  endtask

  task automatic test_byte_en();
    logic [15:0] d;
    logic v1, v2;
    wr_a(5'd14, 16'hABCD, 2'b11);
    wr_a(5'd14, 16'h1234, 2'b01);
    rd_a(1, 5'd14, d, v1, v2);
    tests_run++;
    if (d !== 16'hAB34) begin tests_failed++; $display("FAIL be_low_data: got %h expected ab34", d); end
    tests_run++;
    if (v1 !== 1'b1 || v2 !== 1'b0) begin tests_failed++; $display("FAIL be_valid_pulse: got %b%b expected 10", v1, v2); end
    wr_a(5'd14, 16'hFFFF, 2'b00);
    rd_a(0, 5'd14, d, v1, v2);
    tests_run++;
    if (d !== 16'hAB34) begin tests_failed++; $display("FAIL be_none: got %h expected ab34", d); end
    wr_a(5'd14, 16'h9900, 2'b10);
    rd_a(0, 5'd14, d, v1, v2);
    tests_run++;
    if (d !== 16'h9934) begin tests_failed++; $display("FAIL be_high: got %h expected 9934", d); end
  endtask

  task automatic test_collision();
    // Full-word write with both ports reading the same word in the same cycle.
    wr_en_a = 1'b1; wr_addr_a = 5'd30; wr_data_a = 16'h5555; wr_be_a = 2'b11;
    rd_en_a = 2'b11; rd_addr_a = {5'd30, 5'd30};
    cyc();
    wr_en_a = 1'b0; wr_be_a = 2'b00; rd_en_a = 2'b00;
    tests_run++;
    if (rd_data_a !== 32'h5555_5555 || rd_valid_a !== 2'b11) begin
      tests_failed++; $display("FAIL collide_full: got %h/%b expected 55555555/11", rd_data_a, rd_valid_a);
    end
    // Partial write: the readers see the merged post-write word.
    wr_en_a = 1'b1; wr_addr_a = 5'd30; wr_data_a = 16'hAA00; wr_be_a = 2'b10;
    rd_en_a = 2'b11;
    cyc();
    wr_en_a = 1'b0; wr_be_a = 2'b00; rd_en_a = 2'b00;
    tests_run++;
    if (rd_data_a !== 32'hAA55_AA55) begin tests_failed++; $display("FAIL collide_partial: got %h expected aa55aa55", rd_data_a); end
    cyc();
    tests_run++;
    if (rd_valid_a !== 2'b00 || rd_data_a !== 32'hAA55_AA55) begin
      tests_failed++; $display("FAIL idle_hold: got %h/%b expected aa55aa55/00", rd_data_a, rd_valid_a);
    end
  endtask

  task automatic test_busy_gating();
    logic [15:0] d;
    logic v1, v2;
    logic [1:0] seen_v;
    int n;
    rst_a = 1'b0;
    cyc();
    rst_a = 1'b1;
    wr_en_a = 1'b1; wr_addr_a = 5'd25; wr_data_a = 16'hFFFF; wr_be_a = 2'b11;
    rd_en_a = 2'b11; rd_addr_a = {5'd25, 5'd14};
    seen_v = 2'b00;
    n = 0;
    while (busy_a && n < 200) begin
      cyc();
      seen_v = seen_v | rd_valid_a;
      n++;
    end
    wr_en_a = 1'b0; wr_be_a = 2'b00; rd_en_a = 2'b00;
    tests_run++;
    if (seen_v !== 2'b00) begin tests_failed++; $display("FAIL gate_rd_valid: got %b expected 00", seen_v); end
    tests_run++;
    if (n !== 19) begin tests_failed++; $display("FAIL gate_sweep_len: got %0d expected 19", n); end
    rd_a(1, 5'd25, d, v1, v2);
    tests_run++;
    if (d !== 16'h0000 || v1 !== 1'b1) begin tests_failed++; $display("FAIL gate_word25: got %h/%b expected 0000/1", d, v1); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rst_a = 1'b0;
    cyc();
    rst_a = 1'b1;
    repeat (5) cyc();
    tests_run++;
    if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL mid_sweep_busy: got %b expected 1", busy_a); end
    rst_a = 1'b0;
    #1;
    tests_run++;
    if (busy_a !== 1'b1 || rd_valid_a !== 2'b00 || rd_data_a !== 32'h0) begin
      tests_failed++; $display("FAIL mid_reset_out: got busy=%b valid=%b data=%h expected 1/00/0", busy_a, rd_valid_a, rd_data_a);
    end
    @(negedge clk);
    cyc();
    rst_a = 1'b1;
    count_busy_a(n);
    tests_run++;
    if (n !== 19) begin tests_failed++; $display("FAIL mid_restart_len: got %0d expected 19", n); end
  endtask

  task automatic test_params();
    int n;
    rst_b = 1'b1;
    count_busy_b(n);
    tests_run++;
    if (n !== 64) begin tests_failed++; $display("FAIL wide_sweep_len: got %0d expected 64", n); end
    wr_en_b = 1'b1; wr_addr_b = 6'd14; wr_data_b = 32'hAABB_CCDD; wr_be_b = 4'b1111;
    cyc();
    wr_data_b = 32'h1122_3344; wr_be_b = 4'b0101;
    cyc();
    wr_en_b = 1'b0; wr_be_b = 4'b0000;
    rd_en_b = 3'b101; rd_addr_b = {6'd14, 6'd0, 6'd0};
    cyc();
    rd_en_b = 3'b000;
    tests_run++;
    if (rd_data_b[95:64] !== 32'hAA22_CC44 || rd_valid_b !== 3'b101) begin
      tests_failed++; $display("FAIL wide_be: got %h/%b expected aa22cc44/101", rd_data_b[95:64], rd_valid_b);
    end
    tests_run++;
    if (rd_data_b[31:0] !== 32'h0) begin tests_failed++; $display("FAIL wide_word0: got %h expected 0", rd_data_b[31:0]); end
    cyc();
    tests_run++;
    if (rd_valid_b !== 3'b000) begin tests_failed++; $display("FAIL wide_valid_pulse: got %b expected 000", rd_valid_b); end
  endtask

  initial begin
    rst_a = 1'b0; rd_en_a = '0; rd_addr_a = '0; wr_en_a = 1'b0; wr_addr_a = '0; wr_be_a = '0; wr_data_a = '0;
    rst_b = 1'b0; rd_en_b = '0; rd_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_be_b = '0; wr_data_b = '0;
    test_reset();
    test_sweep();
    test_byte_en();
    test_collision();
    test_busy_gating();
    test_reset_mid_sweep();
    test_params();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
